// File: rtl/inta_sequencer_if.sv
// Bus bundle between the interrupt-acknowledge sequencer and its CPU-side/buffer-side peers.
// The slave modport is the sequencer; the master modport drives requests and INTA.
interface inta_sequencer_if;
    logic       inta_n;
    logic       mode;
    logic [7:0] irr;
    logic [7:0] imr;
    logic [4:0] vec_base;
    logic [2:0] addr_lo;
    logic [7:0] addr_hi;
    logic       eoi;

    logic       int_out;
    logic [7:0] isr;
    logic [7:0] clr_irr;
    logic [1:0] counter;
    logic [7:0] data_out;
    logic       data_en;

    modport master (
        output inta_n, mode, irr, imr, vec_base, addr_lo, addr_hi, eoi,
        input  int_out, isr, clr_irr, counter, data_out, data_en
    );

    modport slave (
        input  inta_n, mode, irr, imr, vec_base, addr_lo, addr_hi, eoi,
        output int_out, isr, clr_irr, counter, data_out, data_en
    );
endinterface

// File: rtl/inta_sequencer.sv
// Interrupt-acknowledge sequencer: fixed priority (IR0 highest), fully nested, 8086/8085 INTA
// byte sequencing, in-service register with non-specific EOI.
module inta_sequencer #(
    parameter int unsigned NUM_IRQ = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    inta_sequencer_if.slave   bus
);

    localparam int unsigned LvlW = $clog2(NUM_IRQ);

    typedef enum logic [1:0] {StIdle, StAck1, StAck2, StAck3} state_e;

    state_e               r_state;
    state_e               w_state_d;

    logic                 r_inta_q;
    logic                 w_fall;
    logic                 w_rise;

    logic [NUM_IRQ-1:0]   w_isr_low;
    logic [NUM_IRQ-1:0]   w_mask;
    logic [NUM_IRQ-1:0]   w_elig;
    logic                 w_any;
    logic [LvlW-1:0]      w_lvl;
    logic [NUM_IRQ-1:0]   w_lvl_onehot;

    logic                 r_mode,     w_mode_d;
    logic [LvlW-1:0]      r_lvl,      w_lvl_d;
    logic [4:0]           r_vec_base, w_vec_base_d;
    logic [2:0]           r_addr_lo,  w_addr_lo_d;
    logic [7:0]           r_addr_hi,  w_addr_hi_d;
    logic                 r_int,      w_int_d;
    logic [NUM_IRQ-1:0]   r_isr,      w_isr_d;
    logic [NUM_IRQ-1:0]   r_clr_irr,  w_clr_irr_d;
    logic [1:0]           r_counter,  w_counter_d;
    logic [7:0]           r_data_out, w_data_out_d;
    logic                 r_data_en,  w_data_en_d;

    assign w_fall = r_inta_q & ~bus.inta_n;
    assign w_rise = ~r_inta_q & bus.inta_n;

    // Only requests strictly above the highest-priority in-service level may interrupt.
    // isr == 0 makes w_isr_low zero and the mask all ones.
    always_comb begin
        w_isr_low    = r_isr & (~r_isr + 1'b1);
        w_mask       = w_isr_low - 1'b1;
        w_elig       = bus.irr & ~bus.imr & w_mask;
        w_any        = |w_elig;
        w_lvl        = LvlW'(NUM_IRQ - 1);
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_lvl = LvlW'(i);
            end
        end
        w_lvl_onehot = NUM_IRQ'(1) << w_lvl;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle: begin
                if (w_fall) begin
                    w_state_d = StAck1;
                end
            end
            StAck1: begin
                if (w_fall) begin
                    w_state_d = StAck2;
                end
            end
            StAck2: begin
                if (r_mode && w_rise) begin
                    w_state_d = StIdle;
                end else if (!r_mode && w_fall) begin
                    w_state_d = StAck3;
                end
            end
            StAck3: begin
                if (w_rise) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_mode_d     = r_mode;
        w_lvl_d      = r_lvl;
        w_vec_base_d = r_vec_base;
        w_addr_lo_d  = r_addr_lo;
        w_addr_hi_d  = r_addr_hi;
        w_clr_irr_d  = '0;
        w_counter_d  = r_counter;
        w_data_out_d = r_data_out;
        w_data_en_d  = r_data_en;
        w_int_d      = (w_state_d == StIdle) && w_any;
        // EOI acts on the pre-acknowledge ISR; a coincident acknowledge ORs its bit in after.
        w_isr_d      = bus.eoi ? (r_isr & (r_isr - 1'b1)) : r_isr;

        case (r_state)
            StIdle: begin
                if (w_fall) begin
                    w_mode_d     = bus.mode;
                    w_lvl_d      = w_lvl;
                    w_vec_base_d = bus.vec_base;
                    w_addr_lo_d  = bus.addr_lo;
                    w_addr_hi_d  = bus.addr_hi;
                    w_counter_d  = 2'd1;
                    if (w_any) begin
                        w_isr_d     = w_isr_d | w_lvl_onehot;
                        w_clr_irr_d = w_lvl_onehot;
                    end
                    if (!bus.mode) begin
                        w_data_out_d = 8'hCD;
                        w_data_en_d  = 1'b1;
                    end
                end
            end
            StAck1: begin
                if (w_rise) begin
                    w_data_en_d = 1'b0;
                end else if (w_fall) begin
                    w_counter_d  = 2'd2;
                    w_data_out_d = r_mode ? {r_vec_base, r_lvl} : {r_addr_lo, r_lvl, 2'b00};
                    w_data_en_d  = 1'b1;
                end
            end
            StAck2: begin
                if (w_rise) begin
                    w_data_en_d = 1'b0;
                    if (r_mode) begin
                        w_counter_d = 2'd0;
                    end
                end else if (w_fall && !r_mode) begin
                    w_counter_d  = 2'd3;
                    w_data_out_d = r_addr_hi;
                    w_data_en_d  = 1'b1;
                end
            end
            StAck3: begin
                if (w_rise) begin
                    w_data_en_d = 1'b0;
                    w_counter_d = 2'd0;
                end
            end
            default: begin
                w_data_en_d = 1'b0;
                w_counter_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inta_q   <= 1'b1;
            r_mode     <= 1'b0;
            r_lvl      <= '0;
            r_vec_base <= '0;
            r_addr_lo  <= '0;
            r_addr_hi  <= '0;
            r_int      <= 1'b0;
            r_isr      <= '0;
            r_clr_irr  <= '0;
            r_counter  <= '0;
            r_data_out <= '0;
            r_data_en  <= 1'b0;
        end else begin
            r_inta_q   <= bus.inta_n;
            r_mode     <= w_mode_d;
            r_lvl      <= w_lvl_d;
            r_vec_base <= w_vec_base_d;
            r_addr_lo  <= w_addr_lo_d;
            r_addr_hi  <= w_addr_hi_d;
            r_int      <= w_int_d;
            r_isr      <= w_isr_d;
            r_clr_irr  <= w_clr_irr_d;
            r_counter  <= w_counter_d;
            r_data_out <= w_data_out_d;
            r_data_en  <= w_data_en_d;
        end
    end

    assign bus.int_out  = r_int;
    assign bus.isr      = r_isr;
    assign bus.clr_irr  = r_clr_irr;
    assign bus.counter  = r_counter;
    assign bus.data_out = r_data_out;
    assign bus.data_en  = r_data_en;

endmodule

// File: tb/tb_inta_sequencer.sv
// Self-checking bench for inta_sequencer: directed scenarios plus randomized sequences checked
// against a priority/ISR reference model.
module tb_inta_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    inta_sequencer_if bus ();

    inta_sequencer #(.NUM_IRQ(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] m_isr;

    // Reference model: nesting limit is the lowest set ISR index.
    function automatic logic [7:0] m_elig(input logic [7:0] irr, input logic [7:0] imr,
                                          input logic [7:0] isr);
        int top = 8;
        logic [7:0] e = '0;
        for (int i = 7; i >= 0; i--) if (isr[i]) top = i;
        for (int i = 0; i < top; i++) if (irr[i] && !imr[i]) e[i] = 1'b1;
        return e;
    endfunction

    function automatic int m_level(input logic [7:0] e);
        for (int i = 0; i < 8; i++) if (e[i]) return i;
        return 7;
    endfunction

    function automatic logic [7:0] m_eoi(input logic [7:0] isr);
        logic [7:0] r = isr;
        for (int i = 0; i < 8; i++) begin
            if (r[i]) begin
                r[i] = 1'b0;
                return r;
            end
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.inta_n = 1'b1; bus.mode = 1'b1; bus.irr = '0; bus.imr = '0;
        bus.vec_base = '0; bus.addr_lo = '0; bus.addr_hi = '0; bus.eoi = 1'b0;
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        m_isr = '0;
    endtask

    // One INTA pulse; samples outputs at the fall, one cycle later, and after the rise.
    task automatic pulse(input int hold, input bit eoi_now, output logic [7:0] d, output logic en,
                         output logic [1:0] c, output logic [7:0] clr, output logic [7:0] clr2,
                         output logic io, output logic en_rise);
        bus.inta_n = 1'b0;
        bus.eoi    = eoi_now;
        tick();
        d = bus.data_out; en = bus.data_en; c = bus.counter; clr = bus.clr_irr; io = bus.int_out;
        bus.eoi = 1'b0;
        tick();
        clr2 = bus.clr_irr;
        repeat (hold - 1) tick();
        bus.inta_n = 1'b1;
        tick();
        en_rise = bus.data_en;
    endtask

    task automatic eoi_pulse();
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
        tick();
    endtask

    task automatic ack86();
        logic [7:0] d, clr, clr2;
        logic en, io, er;
        logic [1:0] c;
        bus.mode = 1'b1;
        tick(); tick();
        pulse(1, 1'b0, d, en, c, clr, clr2, io, er);
        pulse(1, 1'b0, d, en, c, clr, clr2, io, er);
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({bus.int_out, bus.isr, bus.clr_irr, bus.counter, bus.data_out, bus.data_en} !== 28'd0) begin
            bad++; $display("FAIL reset_outputs: got isr=%h cnt=%0d dout=%h en=%b int=%b want all 0",
                            bus.isr, bus.counter, bus.data_out, bus.data_en, bus.int_out);
        end
    endtask

    task automatic test_8086();
        logic [7:0] d, clr, clr2;
        logic en, io, er;
        logic [1:0] c;
        do_reset();
        bus.mode = 1'b1; bus.irr = 8'h08; bus.imr = 8'h00; bus.vec_base = 5'b01000;
        tick(); tick();
        total++; if (bus.int_out !== 1'b1) begin bad++; $display("FAIL 86_int_pre: got %b want 1", bus.int_out); end
        pulse(2, 1'b0, d, en, c, clr, clr2, io, er);
        total++; if (io !== 1'b0) begin bad++; $display("FAIL 86_int_ack: got %b want 0", io); end
        total++; if (clr !== 8'h08 || clr2 !== 8'h00) begin bad++; $display("FAIL 86_clr_irr: got %h,%h want 08,00", clr, clr2); end
        total++; if (en !== 1'b0 || c !== 2'd1) begin bad++; $display("FAIL 86_p1: got en=%b cnt=%0d want en=0 cnt=1", en, c); end
        total++; if (bus.isr !== 8'h08) begin bad++; $display("FAIL 86_isr: got %h want 08", bus.isr); end
        pulse(1, 1'b0, d, en, c, clr, clr2, io, er);
        total++; if (d !== 8'h43 || en !== 1'b1 || c !== 2'd2) begin
            bad++; $display("FAIL 86_p2: got d=%h en=%b cnt=%0d want 43 1 2", d, en, c); end
        total++; if (er !== 1'b0 || bus.counter !== 2'd0) begin
            bad++; $display("FAIL 86_end: got en=%b cnt=%0d want 0 0", er, bus.counter); end
        tick();
        total++; if (bus.int_out !== 1'b0) begin bad++; $display("FAIL 86_int_post: got %b want 0", bus.int_out); end
    endtask

    task automatic test_8085();
        logic [7:0] d, clr, clr2;
        logic en, io, er;
        logic [1:0] c;
        do_reset();
        bus.mode = 1'b0; bus.irr = 8'h20; bus.addr_lo = 3'b101; bus.addr_hi = 8'h12;
        tick(); tick();
        pulse(1, 1'b0, d, en, c, clr, clr2, io, er);
        total++; if (d !== 8'hCD || en !== 1'b1 || c !== 2'd1 || er !== 1'b0) begin
            bad++; $display("FAIL 85_p1: got d=%h en=%b cnt=%0d er=%b want CD 1 1 0", d, en, c, er); end
        pulse(2, 1'b0, d, en, c, clr, clr2, io, er);
        total++; if (d !== 8'hB4 || en !== 1'b1 || c !== 2'd2 || bus.counter !== 2'd2) begin
            bad++; $display("FAIL 85_p2: got d=%h en=%b cnt=%0d/%0d want B4 1 2/2", d, en, c, bus.counter); end
        pulse(1, 1'b0, d, en, c, clr, clr2, io, er);
        total++; if (d !== 8'h12 || en !== 1'b1 || c !== 2'd3 || bus.counter !== 2'd0 || er !== 1'b0) begin
            bad++; $display("FAIL 85_p3: got d=%h en=%b cnt=%0d end=%0d want 12 1 3 0", d, en, c, bus.counter); end
        total++; if (bus.isr !== 8'h20) begin bad++; $display("FAIL 85_isr: got %h want 20", bus.isr); end
    endtask

    task automatic test_masking();
        do_reset();
        bus.imr = 8'h08; bus.irr = 8'h08;
        tick(); tick();
        total++; if (bus.int_out !== 1'b0) begin bad++; $display("FAIL mask_int: got %b want 0", bus.int_out); end
        bus.imr = 8'h00;
        tick(); tick();
        total++; if (bus.int_out !== 1'b1) begin bad++; $display("FAIL unmask_int: got %b want 1", bus.int_out); end
    endtask

    task automatic test_nesting();
        logic [7:0] d, clr, clr2;
        logic en, io, er;
        logic [1:0] c;
        do_reset();
        bus.vec_base = 5'b01000; bus.irr = 8'h04;
        ack86();
        bus.irr = 8'h20;
        tick(); tick();
        total++; if (bus.int_out !== 1'b0) begin bad++; $display("FAIL nest_block: got %b want 0", bus.int_out); end
        bus.irr = 8'h22;
        tick(); tick();
        total++; if (bus.int_out !== 1'b1) begin bad++; $display("FAIL nest_allow: got %b want 1", bus.int_out); end
        pulse(1, 1'b0, d, en, c, clr, clr2, io, er);
        pulse(1, 1'b0, d, en, c, clr, clr2, io, er);
        total++; if (d !== 8'h41 || bus.isr !== 8'h06) begin
            bad++; $display("FAIL nest_lvl: got d=%h isr=%h want 41 06", d, bus.isr); end
    endtask

    task automatic test_spurious();
        logic [7:0] d, clr, clr2;
        logic en, io, er;
        logic [1:0] c;
        do_reset();
        bus.mode = 1'b1; bus.vec_base = 5'b01000; bus.irr = 8'h08;
        tick(); tick();
        bus.irr = 8'h00;
        pulse(1, 1'b0, d, en, c, clr, clr2, io, er);
        total++; if (clr !== 8'h00 || bus.isr !== 8'h00) begin
            bad++; $display("FAIL spur_isr: got clr=%h isr=%h want 00 00", clr, bus.isr); end
        pulse(1, 1'b0, d, en, c, clr, clr2, io, er);
        total++; if (d !== 8'h47) begin bad++; $display("FAIL spur_vec: got %h want 47", d); end
    endtask

    task automatic test_eoi();
        logic [7:0] d, clr, clr2;
        logic en, io, er;
        logic [1:0] c;
        do_reset();
        bus.irr = 8'h08; ack86();
        bus.irr = 8'h02; ack86();
        total++; if (bus.isr !== 8'h0A) begin bad++; $display("FAIL eoi_setup: got %h want 0A", bus.isr); end
        eoi_pulse();
        total++; if (bus.isr !== 8'h08) begin bad++; $display("FAIL eoi_clear: got %h want 08", bus.isr); end
        eoi_pulse();
        eoi_pulse();
        total++; if (bus.isr !== 8'h00) begin bad++; $display("FAIL eoi_empty: got %h want 00", bus.isr); end
        // EOI coincident with the acknowledge: old lowest bit cleared, new bit set.
        bus.irr = 8'h08; ack86();
        bus.irr = 8'h02;
        tick(); tick();
        pulse(1, 1'b1, d, en, c, clr, clr2, io, er);
        total++; if (bus.isr !== 8'h02) begin bad++; $display("FAIL eoi_collide: got %h want 02", bus.isr); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d, clr, clr2;
        logic en, io, er;
        logic [1:0] c;
        do_reset();
        bus.mode = 1'b0; bus.irr = 8'h20; bus.addr_lo = 3'b101; bus.addr_hi = 8'h12;
        tick(); tick();
        pulse(1, 1'b0, d, en, c, clr, clr2, io, er);
        bus.inta_n = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({bus.int_out, bus.isr, bus.clr_irr, bus.counter, bus.data_out, bus.data_en} !== 28'd0) begin
            bad++; $display("FAIL reset_mid: got isr=%h cnt=%0d dout=%h en=%b want all 0",
                            bus.isr, bus.counter, bus.data_out, bus.data_en);
        end
        bus.inta_n = 1'b1;
        tick();
        rst_n = 1'b1;
        tick(); tick();
        pulse(1, 1'b0, d, en, c, clr, clr2, io, er);
        total++; if (c !== 2'd1 || d !== 8'hCD || bus.isr !== 8'h20) begin
            bad++; $display("FAIL reset_fresh: got cnt=%0d d=%h isr=%h want 1 CD 20", c, d, bus.isr); end
    endtask

    task automatic test_random();
        logic [7:0] d, clr, clr2, irr, imr, e, exp_clr, exp_d, ahi;
        logic en, io, er, md, coll, spur;
        logic [1:0] c;
        logic [4:0] vb;
        logic [2:0] alo;
        int lvl;
        do_reset();
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(2) == 0) begin
                eoi_pulse();
                m_isr = m_eoi(m_isr);
            end
            md  = 1'($urandom_range(1));
            irr = 8'($urandom); imr = 8'($urandom) & 8'($urandom);
            vb  = 5'($urandom); alo = 3'($urandom); ahi = 8'($urandom);
            bus.mode = md; bus.irr = irr; bus.imr = imr;
            bus.vec_base = vb; bus.addr_lo = alo; bus.addr_hi = ahi;
            tick(); tick();
            e    = m_elig(irr, imr, m_isr);
            lvl  = m_level(e);
            spur = (e == 8'h00);
            total++; if (bus.int_out !== (e != 0)) begin
                bad++; $display("FAIL rnd_int[%0d]: got %b want %b", n, bus.int_out, e != 0); end
            coll = ($urandom_range(3) == 0);
            if (coll) m_isr = m_eoi(m_isr);
            if (!spur) m_isr = m_isr | 8'(1 << lvl);
            exp_clr = spur ? 8'h00 : 8'(1 << lvl);
            pulse($urandom_range(1, 3), coll, d, en, c, clr, clr2, io, er);
            total++; if (c !== 2'd1 || clr !== exp_clr || clr2 !== 8'h00 || en !== !md ||
                         (!md && d !== 8'hCD) || bus.isr !== m_isr) begin
                bad++; $display("FAIL rnd_p1[%0d]: got cnt=%0d clr=%h/%h en=%b d=%h isr=%h want 1 %h/00 %b isr=%h",
                                n, c, clr, clr2, en, d, bus.isr, exp_clr, !md, m_isr);
            end
            bus.irr = 8'($urandom); bus.imr = 8'($urandom); bus.mode = 1'($urandom_range(1));
            exp_d = md ? 8'(vb * 8 + lvl) : 8'(alo * 32 + lvl * 4);
            pulse($urandom_range(1, 3), 1'b0, d, en, c, clr, clr2, io, er);
            total++; if (d !== exp_d || en !== 1'b1 || c !== 2'd2 || er !== 1'b0) begin
                bad++; $display("FAIL rnd_p2[%0d]: got d=%h en=%b cnt=%0d want %h 1 2", n, d, en, c, exp_d); end
            if (!md) begin
                pulse($urandom_range(1, 3), 1'b0, d, en, c, clr, clr2, io, er);
                total++; if (d !== ahi || en !== 1'b1 || c !== 2'd3) begin
                    bad++; $display("FAIL rnd_p3[%0d]: got d=%h en=%b cnt=%0d want %h 1 3", n, d, en, c, ahi); end
            end
            total++; if (bus.counter !== 2'd0 || bus.data_en !== 1'b0) begin
                bad++; $display("FAIL rnd_end[%0d]: got cnt=%0d en=%b want 0 0", n, bus.counter, bus.data_en); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        m_isr = '0;
        test_reset();
        test_8086();
        test_8085();
        test_masking();
        test_nesting();
        test_spurious();
        test_eoi();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inta_sequencer.md
Name: inta_sequencer

Overview:
- Interrupt-acknowledge control stage that sits directly upstream of the data bus buffer in the PIC.
- Resolves the highest-priority pending request and raises INT to the CPU.
- Counts CPU INTA pulses and supplies the buffer with the pulse count, the byte to drive, and the drive enable.
- Maintains the in-service register (ISR) and handles non-specific EOI.
- Fixed priority (IR0 highest), fully nested mode.

Parameters:
- NUM_IRQ, 8, number of request lines. Fixed at 8; other values are unsupported.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- inta_n  in  1  CPU acknowledge, active-low, already synchronous to clk.
- mode  in  1  1 = 8086 mode (two INTA pulses), 0 = 8080/85 mode (three pulses).
- irr  in  8  latched interrupt requests.
- imr  in  8  mask; 1 = masked.
- vec_base  in  5  T7..T3 of the 8086 vector.
- addr_lo  in  3  A7..A5 of the 8085 CALL address (interval 4).
- addr_hi  in  8  A15..A8 of the 8085 CALL address.
- eoi  in  1  one-cycle non-specific EOI strobe.
- int_out  out  1  INT request to CPU.
- isr  out  8  in-service register.
- clr_irr  out  8  one-cycle pulse clearing the acknowledged IRR bit.
- counter  out  2  INTA pulses seen in the current sequence (0..3).
- data_out  out  8  byte for the buffer to drive.
- data_en  out  1  buffer drive enable.

Behaviour:
- Reset (asynchronous, rst_n = 0): all outputs 0, state IDLE, inta_n history register = 1. Reset mid-sequence aborts the sequence; the partial ISR set is lost.
- Edge detect:
  - inta_q is a registered copy of inta_n.
  - fall = inta_q & ~inta_n; rise = ~inta_q & inta_n.
  - All actions occur at the clock edge that samples fall or rise.
- Eligibility:
  - elig = irr & ~imr, restricted to bits of strictly higher priority (lower index) than the lowest-index set ISR bit.
  - lvl = lowest-index set bit of elig.
- int_out: registered; equals |elig while state = IDLE; forced 0 in every other state.
- FSM states: IDLE, ACK1, ACK2, ACK3.
- IDLE + fall:
  - Latch mode and lvl. If elig = 0, latch lvl = 7 (spurious) and set no ISR bit.
  - Otherwise set isr[lvl] and pulse clr_irr[lvl] for one cycle.
  - counter <= 1; go to ACK1.
  - Byte for pulse 1: 8086 mode, data_en stays 0; 8085 mode, data_out = 8'hCD and data_en = 1.
- ACK1 + rise: data_en <= 0.
- ACK1 + fall: counter <= 2; go to ACK2.
  - 8086 mode: data_out = {vec_base, lvl}.
  - 8085 mode: data_out = {addr_lo, lvl, 2'b00}.
  - data_en <= 1.
- ACK2 + rise:
  - 8086 mode: data_en <= 0, counter <= 0, go to IDLE.
  - 8085 mode: data_en <= 0, stay in ACK2 awaiting the third pulse.
- ACK2 + fall (8085 mode only): counter <= 3, data_out = addr_hi, data_en <= 1, go to ACK3.
- ACK3 + rise: data_en <= 0, counter <= 0, go to IDLE.
- Latched values: data_out holds its last value when data_en = 0. Changes on irr, imr, mode or vec_base during a sequence do not affect it.
- EOI:
  - eoi clears the lowest-index set ISR bit; no effect if isr = 0.
  - Accepted in any state.
  - If eoi coincides with the ACK1 ISR set, the clear is evaluated on the previous ISR value and the new bit is then set.
- Extra pulses: fall events in ACK3, or in ACK2 when in 8086 mode, are ignored.

Test Plan:
- 8086 mode: mode=1, irr=0x08, imr=0, vec_base=5'b01000; two INTA pulses.
  -> int_out=1 before the first pulse, then 0. clr_irr=0x08 for one cycle, isr=0x08. Pulse 1: data_en=0. Pulse 2: data_out=0x43, data_en=1, counter=2. Returns to IDLE with counter=0.
- 8085 mode: mode=0, irr=0x20, addr_lo=3'b101, addr_hi=0x12; three pulses.
  -> data_out sequence 0xCD, 0xB4, 0x12 with counter 1, 2, 3. isr=0x20.
- Masking and nesting:
  - imr=0x08, irr=0x08 -> int_out=0.
  - isr=0x04 with irr=0x20 -> int_out=0; then irr=0x22 -> int_out=1 and lvl=1.
- Spurious: irr drops to 0 before the first INTA in 8086 mode, vec_base=5'b01000.
  -> vector 0x47, isr unchanged, clr_irr=0.
- EOI: isr=0x0A, pulse eoi -> isr=0x08. eoi with isr=0 -> no change.
- Reset: assert rst_n=0 during ACK2 in 8085 mode.
  -> all outputs 0 immediately. The next INTA starts a fresh sequence with counter=1.
